// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// Shift-add multiply, restoring divide, one bit per cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int W2 = 2 * WIDTH;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic [WIDTH-1:0] araw_q, araw_d;
  logic             div_q, div_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             op_mul;
  logic             op_div;
  logic             op_sgn;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_nxt;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH+1:0] div_diff;
  logic [W2-1:0]    div_nxt;

  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // Decode the request and form operand magnitudes and sign flags
  always_comb begin
    op_mul = 1'b0;
    op_div = 1'b0;
    op_sgn = 1'b0;
    unique case (1'b1)
      (op == OP_MULT):  begin op_mul = 1'b1; op_sgn = 1'b1; end
      (op == OP_MULTU): op_mul = 1'b1;
      (op == OP_DIV):   begin op_div = 1'b1; op_sgn = 1'b1; end
      (op == OP_DIVU):  op_div = 1'b1;
      default: ;
    endcase
    a_neg = op_sgn & srca[WIDTH-1];
    b_neg = op_sgn & srcb[WIDTH-1];
    a_mag = a_neg ? -srca : srca;
    b_mag = b_neg ? -srcb : srcb;
  end

  // One iteration step: multiply adds then shifts right,
  // divide shifts left and subtracts if the divisor fits.
  // Upper half of acc is the partial remainder, lower the quotient.
  always_comb begin
    mul_sum  = {1'b0, acc_q[W2-1:WIDTH]}
             + (acc_q[0] ? {1'b0, bmag_q} : '0);
    mul_nxt  = {mul_sum, acc_q[WIDTH-1:1]};
    div_sh   = acc_q[W2-1:WIDTH-1];
    div_diff = {1'b0, div_sh} - {2'b00, bmag_q};
    if (div_diff[WIDTH+1])
      div_nxt = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    else
      div_nxt = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  // Sign correction of the unsigned result
  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = rneg_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
  end

  // Next-state and register-update logic for the sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    bmag_d  = bmag_q;
    araw_d  = araw_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op_mul || op_div) begin
            acc_d   = {{WIDTH{1'b0}}, a_mag};
            bmag_d  = b_mag;
            araw_d  = srca;
            div_d   = op_div;
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
            dz_d    = op_div && (srcb == '0);
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = S_RUN;
          end else if (op == OP_MTHI) begin
            hi_d = srca;
          end else if (op == OP_MTLO) begin
            lo_d = srca;
          end
        end
      end
      S_RUN: begin
        acc_d = div_q ? div_nxt : mul_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1))
          state_d = S_FIX;
      end
      S_FIX: begin
        if (!div_q) begin
          hi_d = prod_fix[W2-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (dz_q) begin
          hi_d = araw_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset discards any in-flight operation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      bmag_q  <= '0;
      araw_q  <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      bmag_q  <= bmag_d;
      araw_q  <= araw_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit.
// Driver pushes expected HI/LO; monitor pops on done.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .srca  (srca),
    .srcb  (srcb),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          e0;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every done pulse against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_done: got done=1 expected none");
      end else begin
        e = sb.pop_front();
        chk({e.name, "_hi"}, hi, e.hi);
        chk({e.name, "_lo"}, lo, e.lo);
        chk({e.name, "_lat"}, cyc - e.e0, 33);
        chk({e.name, "_pulse"}, {31'b0, prev_done}, 32'd0);
      end
    end
    prev_done <= done;
  end

  // Called at a negedge; returns 1ns after the accepting edge
  task automatic issue(string name, logic [2:0] o,
                       logic [31:0] a, logic [31:0] b,
                       logic [31:0] eh, logic [31:0] el,
                       bit push);
    exp_t e;
    start = 1'b1;
    op    = o;
    srca  = a;
    srcb  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'b000;
    if (push) begin
      e.name = name;
      e.hi   = eh;
      e.lo   = el;
      e.e0   = cyc;
      sb.push_back(e);
    end
  endtask

  // Full op; ends at the negedge after done, ready to reissue
  task automatic run_op(string name, logic [2:0] o,
                        logic [31:0] a, logic [31:0] b,
                        logic [31:0] eh, logic [31:0] el);
    int n;
    issue(name, o, a, b, eh, el, 1'b1);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    chk({name, "_busy"}, n, 32'd33);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    op    = 3'b000;
    srca  = '0;
    srcb  = '0;
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_op("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFE, 32'h00000001);
    run_op("mult_m7x3", 3'b000, 32'hFFFFFFF9, 32'h00000003,
           32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("div_m7d2", 3'b010, 32'hFFFFFFF9, 32'h00000002,
           32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_100d7", 3'b011, 32'd100, 32'd7,
           32'd2, 32'd14);
    run_op("divu_5d0", 3'b011, 32'd5, 32'd0,
           32'd5, 32'hFFFFFFFF);
    run_op("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF,
           32'h00000000, 32'h80000000);
    run_op("div_7dm2", 3'b010, 32'd7, 32'hFFFFFFFE,
           32'd1, 32'hFFFFFFFD);
    run_op("div_m5d0", 3'b010, 32'hFFFFFFFB, 32'd0,
           32'hFFFFFFFB, 32'hFFFFFFFF);
    run_op("mult_min2", 3'b000, 32'h80000000, 32'h80000000,
           32'h40000000, 32'h00000000);

    issue("mthi", 3'b100, 32'h12345678, 32'd0, 0, 0, 1'b0);
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    issue("mtlo", 3'b101, 32'h9ABCDEF0, 32'd0, 0, 0, 1'b0);
    chk("mtlo_lo", lo, 32'h9ABCDEF0);
    chk("mtlo_hi", hi, 32'h12345678);
    chk("mtlo_busy", {31'b0, busy}, 32'd0);
    chk("mtlo_done", {31'b0, done}, 32'd0);
    @(negedge clk);

    issue("undef", 3'b111, 32'hFFFFFFFF, 32'h1, 0, 0, 1'b0);
    chk("undef_hi", hi, 32'h12345678);
    chk("undef_lo", lo, 32'h9ABCDEF0);
    chk("undef_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);

    issue("mult_2p32", 3'b000, 32'h00010000, 32'h00010000,
          32'h00000001, 32'h00000000, 1'b1);
    repeat (5) @(negedge clk);
    issue("mthi_busy", 3'b100, 32'hDEADBEEF, 32'd0,
          0, 0, 1'b0);
    chk("mthi_ign_hi", hi, 32'h12345678);
    @(negedge clk);
    issue("multu_busy", 3'b001, 32'd3, 32'd3, 0, 0, 1'b0);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("busy_drain", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("no_queue_busy", {31'b0, busy}, 32'd0);
    chk("no_queue_hi", hi, 32'h00000001);

    issue("mult_rst", 3'b000, 32'd5, 32'd5, 32'd0, 32'd25, 1'b1);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_op("multu_6x7", 3'b001, 32'd6, 32'd7, 32'd0, 32'd42);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
